// File: rtl/br_credit_sender_buffered.sv
// Credit/valid link transmitter: a ready/valid skid FIFO feeding a registered
// pop interface that only sends while a spendable credit is held.
module br_credit_sender_buffered #(
    parameter int Width     = 8,
    parameter int Depth     = 4,
    parameter int MaxCredit = 8,
    localparam int CW = $clog2(MaxCredit + 1),
    localparam int IW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             push_ready,
    input  logic             push_valid,
    input  logic [Width-1:0] push_data,
    output logic             pop_sender_in_reset,
    input  logic             pop_receiver_in_reset,
    input  logic             pop_credit,
    output logic             pop_valid,
    output logic [Width-1:0] pop_data,
    input  logic [CW-1:0]    credit_initial,
    input  logic [CW-1:0]    credit_withhold,
    output logic [CW-1:0]    credit_count,
    output logic [CW-1:0]    credit_available,
    output logic [IW-1:0]    buffer_items
);

    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic [1:0] {
        IN_RESET = 2'd0,
        ACTIVE   = 2'd1,
        RX_RESET = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [IW-1:0]    items;
    logic [CW-1:0]    count, count_next;
    logic             push_fire, have_data, send, credit_overflow;
    logic [Width-1:0] send_data;

    assign push_ready = (state != IN_RESET) && (items != IW'(Depth));
    assign push_fire  = push_valid && push_ready;
    assign have_data  = (items != '0) || push_fire;
    assign send       = (state == ACTIVE) && !pop_receiver_in_reset && have_data &&
                        (count > credit_withhold);
    // An empty buffer forwards the incoming flit straight to the output flop.
    assign send_data  = (items == '0) ? push_data : mem[rd_ptr];

    assign credit_count     = count;
    assign credit_available = (count > credit_withhold) ? (count - credit_withhold) : '0;
    assign buffer_items     = items;

    always_comb begin
        state_next      = state;
        count_next      = count;
        credit_overflow = 1'b0;
        case (state)
            IN_RESET, RX_RESET: begin
                if (pop_receiver_in_reset) begin
                    count_next = '0;
                end else begin
                    state_next = ACTIVE;
                    count_next = credit_initial;
                end
            end
            ACTIVE: begin
                if (pop_receiver_in_reset) begin
                    state_next = RX_RESET;
                    count_next = '0;
                end else if (pop_credit && !send && (count == CW'(MaxCredit))) begin
                    credit_overflow = 1'b1;
                end else begin
                    count_next = count + CW'(pop_credit) - CW'(send);
                end
            end
            default: begin
                state_next = IN_RESET;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IN_RESET;
            pop_sender_in_reset <= 1'b1;
            pop_valid           <= 1'b0;
            pop_data            <= '0;
            count               <= '0;
            items               <= '0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
        end else begin
            state               <= state_next;
            pop_sender_in_reset <= (state_next == IN_RESET);
            pop_valid           <= send;
            pop_data            <= send ? send_data : '0;
            count               <= count_next;
            items               <= items + IW'(push_fire) - IW'(send);
            if (push_fire) begin
                wr_ptr <= (wr_ptr == PW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (send) begin
                rd_ptr <= (rd_ptr == PW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flags a credit returned while already saturated; the count does not wrap.
    br_credit_overflow: cover property (@(posedge clk) disable iff (!rst_n) credit_overflow);

endmodule
